instruction_fetch_unit: RTL and testbench

//  PC generator and fetch buffer directly upstream of InstructionMemory. Drives the fetch

---
 rtl/instruction_fetch_unit.sv | 172 +++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_unit
// Purpose  : PC generator and small fetch buffer that sits directly upstream
//            of a 1-cycle synchronous instruction memory. The unit issues
//            fetch addresses, captures the returned words together with their
//            PCs, and hands (pc, instr) pairs to decode over valid/ready.
//            It stops issuing when decode backpressure would overflow the
//            buffer, and it flushes and reloads the PC on a redirect.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   RESET_PC   PC of the first fetch after reset
//   DEPTH      fetch buffer entries (power of 2, >= 2)
// Optional feature macro
//   FETCH_MISALIGN_TRAP_EN  defined   : a redirect target with [1:0] != 0
//                                       raises misalign_trap and halts fetch
//                                       until an aligned redirect or reset
//                           undefined : target[1:0] forced to 0 on load,
//                                       misalign_trap tied low
// Ports
//   clk              in   1   clock, all state updates on posedge
//   rst              in   1   synchronous active-high reset
//   fetch_en         in   1   allow new fetches (buffer drains regardless)
//   imem_addr        out  32  fetch address (current PC)
//   imem_req         out  1   fetch issued this cycle
//   imem_rdata       in   32  instruction word, valid the cycle after imem_req
//   redirect_valid   in   1   load redirect_target into the PC this cycle
//   redirect_target  in   32  new PC
//   out_valid        out  1   buffer head valid
//   out_ready        in   1   decode accepts buffer head
//   out_instr        out  32  head instruction
//   out_pc           out  32  head PC
//   misalign_trap    out  1   misaligned redirect trap (feature macro only)
// ============================================================================
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        misalign_trap
);

  // Pointer width covers DEPTH entries; count width covers 0..DEPTH.
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_V = (CW + 1)'(DEPTH);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [31:0]   pc_q;
  logic          inflight_q;
  logic [31:0]   inflight_pc_q;
  logic [CW-1:0] count_q;
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [31:0]   buf_instr [DEPTH];
  logic [31:0]   buf_pc    [DEPTH];

  logic          trap_active;
  logic [31:0]   redirect_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic          trap_q;
  assign trap_active = trap_q;
  // Target is loaded unmodified so the trapping PC stays visible.
  assign redirect_pc = redirect_target;
`else
  assign trap_active = 1'b0;
  // Low bits are dropped so fetch always stays word aligned.
  assign redirect_pc = redirect_target & 32'hFFFF_FFFC;
`endif

  // --------------------------------------------------------------------------
  // Handshake and issue credit
  // --------------------------------------------------------------------------
  logic          deq;
  logic          issue;
  logic [CW:0]   occupancy;

  assign deq = (count_q != '0) & out_ready;

  // Entries held plus the word already on its way back, less the one leaving
  // now. Issuing only while this is below DEPTH means every returning word is
  // guaranteed a free slot, so the buffer can never overflow.
  assign occupancy = {1'b0, count_q} + (CW + 1)'(inflight_q) - (CW + 1)'(deq);

  assign issue = ~rst & fetch_en & ~redirect_valid & ~trap_active &
                 (occupancy < DEPTH_V);

  // --------------------------------------------------------------------------
  // PC, in-flight tracking, pointers and occupancy
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_q        <= 1'b0;
`endif
    end else if (redirect_valid) begin
      // Flush: buffered entries and the in-flight response are discarded.
      // A head accepted by decode this cycle still counts as delivered.
      pc_q       <= redirect_pc;
      inflight_q <= 1'b0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_q     <= (redirect_target[1:0] != 2'b00);
`endif
    end else begin
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= pc_q;
        pc_q          <= pc_q + 32'd4;
      end
      if (inflight_q) begin
        tail_q <= tail_q + PW'(1);
      end
      if (deq) begin
        head_q <= head_q + PW'(1);
      end
      unique case ({inflight_q, deq})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Buffer storage: data only, no reset needed since count gates visibility.
  always_ff @(posedge clk) begin
    if (!rst && !redirect_valid && inflight_q) begin
      buf_instr[tail_q] <= imem_rdata;
      buf_pc[tail_q]    <= inflight_pc_q;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign imem_addr = pc_q;
  assign imem_req  = issue;
  assign out_valid = (count_q != '0);
  assign out_instr = buf_instr[head_q];
  assign out_pc    = buf_pc[head_q];

`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign_trap = trap_q;
`else
  assign misalign_trap = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch_unit
// Purpose  : Self-checking bench for instruction_fetch_unit. Two instances:
//            the main one (RESET_PC=0) receives stalls, redirects and resets;
//            a second one (RESET_PC=FFFF_FFF8) streams freely to show PC wrap.
//            Each issued fetch pushes its expected (pc, instr) into a queue;
//            every accepted output is popped and compared.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        out_ready;

  logic [31:0] imem_addr, imem_rdata, out_instr, out_pc;
  logic        imem_req, out_valid, misalign_trap;

  logic [31:0] imem_addr2, imem_rdata2, out_instr2, out_pc2;
  logic        imem_req2, out_valid2, misalign_trap2;
  logic        fetch_en2 = 1'b1;
  logic        out_ready2 = 1'b1;
  logic        redirect_valid2 = 1'b0;
  logic [31:0] redirect_target2 = 32'h0;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  logic [31:0] q_pc[$], q_in[$], q_pc2[$], q_in2[$];
  logic [31:0] exp_pc, exp_pc2;
  logic        exp_trap;
  logic [31:0] head_pc;

  always #5 clk = ~clk;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .misalign_trap(misalign_trap)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut2 (
    .clk(clk), .rst(rst), .fetch_en(fetch_en2),
    .imem_addr(imem_addr2), .imem_req(imem_req2), .imem_rdata(imem_rdata2),
    .redirect_valid(redirect_valid2), .redirect_target(redirect_target2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_instr(out_instr2), .out_pc(out_pc2), .misalign_trap(misalign_trap2)
  );

  // Memory image: word i at byte address 4*i, tagged so it differs from the PC.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {2'b00, a[31:2]} ^ 32'h5A00_0000;
  endfunction

  always @(posedge clk) begin
    if (imem_req === 1'b1)  imem_rdata  <= mem_word(imem_addr);
    if (imem_req2 === 1'b1) imem_rdata2 <= mem_word(imem_addr2);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard monitor, main instance.
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (q_pc.size() == 0) check("sb_underflow", out_pc, 32'hXXXX_XXXX);
        else begin
          check("sb_pc", out_pc, q_pc[0]);
          check("sb_instr", out_instr, q_in[0]);
          void'(q_pc.pop_front());
          void'(q_in.pop_front());
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      check("trap_out", misalign_trap, exp_trap);
      if (exp_trap) check("trap_noreq", imem_req, 0);
`else
      check("trap_tied", misalign_trap, 0);
`endif
      if (rst) begin
        q_pc.delete(); q_in.delete();
        exp_pc = 32'h0; exp_trap = 1'b0;
      end else if (redirect_valid) begin
        check("redir_noreq", imem_req, 0);
        q_pc.delete(); q_in.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
        exp_pc = redirect_target;
        exp_trap = (redirect_target[1:0] != 2'b00);
`else
        exp_pc = redirect_target & 32'hFFFF_FFFC;
`endif
      end else if (imem_req === 1'b1) begin
        check("issue_addr", imem_addr, exp_pc);
        q_pc.push_back(exp_pc);
        q_in.push_back(mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
      end
    end
  end

  // Scoreboard monitor, wrap-around instance.
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid2 === 1'b1) begin
        if (q_pc2.size() == 0) check("sb2_underflow", out_pc2, 32'hXXXX_XXXX);
        else begin
          check("sb2_pc", out_pc2, q_pc2[0]);
          check("sb2_instr", out_instr2, q_in2[0]);
          void'(q_pc2.pop_front());
          void'(q_in2.pop_front());
        end
      end
      if (rst) begin
        q_pc2.delete(); q_in2.delete();
        exp_pc2 = 32'hFFFF_FFF8;
      end else if (imem_req2 === 1'b1) begin
        check("issue2_addr", imem_addr2, exp_pc2);
        q_pc2.push_back(exp_pc2);
        q_in2.push_back(mem_word(exp_pc2));
        exp_pc2 = exp_pc2 + 32'd4;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1; fetch_en = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_target = 32'h0;
    exp_pc = 32'h0; exp_pc2 = 32'hFFFF_FFF8; exp_trap = 1'b0;
    ticks(2);
    mon_en = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_imem_req", imem_req, 0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_trap", misalign_trap, 0);
    check("rst2_imem_addr", imem_addr2, 32'hFFFF_FFF8);
    check("rst2_out_valid", out_valid2, 0);

    // Test 1: first fetch and latency
    tick(); rst = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("t1_c0_req", imem_req, 1);
    check("t1_c0_addr", imem_addr, 32'h0);
    check("t1_c0_valid", out_valid, 0);
    tick(); @(negedge clk);
    check("t1_c1_valid", out_valid, 0);
    check("t1_c1_addr", imem_addr, 32'h4);
    tick(); @(negedge clk);
    check("t1_c2_valid", out_valid, 1);
    check("t1_c2_pc", out_pc, 32'h0);
    check("t4_c2_pc", out_pc2, 32'hFFFF_FFF8);
    tick(); @(negedge clk);
    check("t1_c3_pc", out_pc, 32'h4);
    check("t4_c3_pc", out_pc2, 32'hFFFF_FFFC);
    tick(); @(negedge clk);
    check("t4_c4_pc", out_pc2, 32'h0000_0000);
    ticks(5);

    // Test 2: backpressure holds head, issue stops at full
    out_ready = 1'b0;
    @(negedge clk);
    head_pc = out_pc;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_valid", out_valid, 1);
      check("t2_head_stable", out_pc, head_pc);
      if (i >= 1) check("t2_no_issue", imem_req, 0);
      tick();
    end
    out_ready = 1'b1;
    ticks(8);

    // Test 3: redirect mid-stream
    redirect_valid = 1'b1; redirect_target = 32'h0000_0100;
    tick(); redirect_valid = 1'b0;
    @(negedge clk);
    check("t3_r1_valid", out_valid, 0);
    check("t3_r1_req", imem_req, 1);
    check("t3_r1_addr", imem_addr, 32'h100);
    tick(); @(negedge clk);
    check("t3_r2_valid", out_valid, 0);
    tick(); @(negedge clk);
    check("t3_r3_valid", out_valid, 1);
    check("t3_r3_pc", out_pc, 32'h100);
    tick(); @(negedge clk);
    check("t3_r4_pc", out_pc, 32'h104);
    ticks(4);

    // Redirect while fetch is disabled
    fetch_en = 1'b0;
    redirect_valid = 1'b1; redirect_target = 32'h0000_0300;
    tick(); redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("fe0_no_issue", imem_req, 0);
      tick();
    end
    fetch_en = 1'b1;
    @(negedge clk);
    check("fe1_req", imem_req, 1);
    check("fe1_addr", imem_addr, 32'h300);
    ticks(5);

    // Test 5: reset with a full buffer
    out_ready = 1'b0;
    ticks(4);
    @(negedge clk);
    check("t5_full_valid", out_valid, 1);
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("t5_valid", out_valid, 0);
    check("t5_addr", imem_addr, 32'h0);
    tick(); tick(); @(negedge clk);
    check("t5_c2_valid", out_valid, 1);
    check("t5_c2_pc", out_pc, 32'h0);
    check("t5_c2_pc2", out_pc2, 32'hFFFF_FFF8);
    ticks(4);

    // Test 6: misaligned redirect
    redirect_valid = 1'b1; redirect_target = 32'h0000_0102;
    tick(); redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t6_trap", misalign_trap, 1);
      check("t6_no_issue", imem_req, 0);
      tick();
    end
    redirect_valid = 1'b1; redirect_target = 32'h0000_0200;
    tick(); redirect_valid = 1'b0;
    @(negedge clk);
    check("t6_trap_clr", misalign_trap, 0);
    check("t6_addr", imem_addr, 32'h200);
    tick(); tick(); @(negedge clk);
    check("t6_pc", out_pc, 32'h200);
`else
    @(negedge clk);
    check("t6_req", imem_req, 1);
    check("t6_addr", imem_addr, 32'h100);
    tick(); tick(); @(negedge clk);
    check("t6_pc", out_pc, 32'h100);
`endif
    ticks(4);

    // Drain: everything issued must have been delivered
    fetch_en = 1'b0; out_ready = 1'b1;
    ticks(5);
    @(negedge clk);
    check("sb_drain", q_pc.size(), 0);
    check("drain_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
